ssp_frame_sched: RTL and testbench

Two-requester scheduler for the shared SSP transmit/receive path, running in the PCLK domain. It grants the SSP to one requester at a time and feeds that requester's bytes into the transmit FIFO write port. Each received byte (one RECV pulse per frame) is routed back to the requester that owns the current burst. The block sits between the two client blocks and the SSP Tx FIFO / receive logic, and ensures received bytes are never delivered to the wrong owner.

---
 rtl/ssp_sched_pkg.sv | 17 +
 rtl/ssp_frame_sched_rr_arb2.sv | 17 +
 rtl/ssp_frame_sched.sv | 141 ++++++++++++++
 tb/tb_ssp_frame_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_sched_pkg.sv
// ssp_sched_pkg: shared types and constants for the SSP frame scheduler.
//   state_t      : scheduler FSM states
//   CNT_W, TO_W  : widths of the burst/outstanding counters and the timeout counter
//   REQ_A, REQ_B : requester index constants
package ssp_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int TO_W  = 8;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
endpackage

// File: rtl/ssp_frame_sched_rr_arb2.sv
// rr_arb2: two-way round-robin picker, purely combinational.
//   req[1:0] : request vector
//   prio     : index that wins when both request
//   gnt[1:0] : one-hot pick (zero when nothing requests)
//   idx      : index of the pick (don't-care when req is zero)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       idx
);
  always_comb begin
    idx = req[prio] ? prio : ~prio;
    gnt = 2'b00;
    if (req != 2'b00) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/ssp_frame_sched.sv
// ssp_frame_sched: grants the shared SSP path to one of two requesters at a
// time, streams the owner's bytes into the Tx FIFO and routes each received
// byte back to the owner of the current burst.
//   PCLK, CLEAR_B        : clock, async active-low reset
//   REQ, TXD0/1, LAST    : requester byte requests, data, last-byte flags
//   GNT, ACK             : registered one-hot grant, combinational accept strobe
//   TX_WR, TxDATA, TX_FULL : Tx FIFO write port
//   RxDATA, RECV         : received byte and its one-cycle valid pulse
//   RDATA, RVALID        : registered received byte, one-hot owner pulse
//   BUSY, ERR            : not-idle flag, one-cycle timeout/stray-RECV pulse
module ssp_frame_sched
  import ssp_sched_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  input  logic [1:0] REQ,
  input  logic [7:0] TXD0,
  input  logic [7:0] TXD1,
  input  logic [1:0] LAST,
  output logic [1:0] GNT,
  output logic [1:0] ACK,
  output logic       TX_WR,
  output logic [7:0] TxDATA,
  input  logic       TX_FULL,
  input  logic [7:0] RxDATA,
  input  logic       RECV,
  output logic [7:0] RDATA,
  output logic [1:0] RVALID,
  output logic       BUSY,
  output logic       ERR
);
  localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);
  localparam logic [TO_W-1:0]  TMO  = TO_W'(TIMEOUT);

  state_t           state;
  logic             g, prio;
  logic [CNT_W-1:0] outstanding, burst;
  logic [TO_W-1:0]  to_cnt;

  logic [1:0]       arb_gnt;
  logic             arb_idx;
  logic             wr, rx_ok, rx_stray, timeout;
  logic [CNT_W-1:0] out_nxt, burst_nxt;
  logic [TO_W-1:0]  to_nxt;

  rr_arb2 u_arb (
    .req  (REQ),
    .prio (prio),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    wr        = (state == GRANT) && REQ[g] && !TX_FULL;
    TX_WR     = wr;
    ACK       = wr ? GNT : 2'b00;
    TxDATA    = (g == 1'(REQ_A)) ? TXD0 : TXD1;
    // A byte is only deliverable if some write is still awaiting its echo.
    rx_ok     = RECV && (state != IDLE) && (outstanding != '0);
    rx_stray  = RECV && !rx_ok;
    out_nxt   = outstanding + CNT_W'(wr) - CNT_W'(rx_ok);
    burst_nxt = burst + CNT_W'(wr);
    to_nxt    = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
    // Any RECV restarts the watchdog, so it can only fire on a quiet cycle.
    timeout   = (state == DRAIN) && !RECV && (to_nxt == TMO);
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state       <= IDLE;
      GNT         <= 2'b00;
      g           <= 1'b0;
      prio        <= 1'b0;
      outstanding <= '0;
      burst       <= '0;
      to_cnt      <= '0;
      RDATA       <= 8'h00;
      RVALID      <= 2'b00;
      ERR         <= 1'b0;
    end else begin
      ERR         <= rx_stray || timeout;
      RVALID      <= rx_ok ? GNT : 2'b00;
      if (rx_ok) RDATA <= RxDATA;
      outstanding <= out_nxt;

      case (state)
        IDLE: begin
          if (REQ != 2'b00) begin
            state <= GRANT;
            GNT   <= arb_gnt;
            g     <= arb_idx;
            burst <= '0;
          end
        end
        GRANT: begin
          burst <= burst_nxt;
          if (wr && (LAST[g] || burst_nxt == BMAX)) begin
            state  <= DRAIN;
            to_cnt <= '0;
          end else if (!REQ[g]) begin
            if (burst == '0) begin
              // Requester withdrew before sending anything: nothing to drain.
              state <= IDLE;
              GNT   <= 2'b00;
            end else begin
              state  <= DRAIN;
              to_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (timeout) begin
            state       <= IDLE;
            GNT         <= 2'b00;
            prio        <= ~prio;
            outstanding <= '0;
            burst       <= '0;
            to_cnt      <= '0;
          end else if (out_nxt == '0) begin
            state  <= IDLE;
            GNT    <= 2'b00;
            prio   <= ~g;
            burst  <= '0;
            to_cnt <= '0;
          end else begin
            to_cnt <= RECV ? '0 : to_nxt;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ssp_frame_sched.sv
// tb_ssp_frame_sched: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected Tx writes ({owner,data}) and expected received
// bytes; a negedge monitor pops and compares whenever TX_WR or RVALID fires.
module tb_ssp_frame_sched;
  import ssp_sched_pkg::*;

  localparam int BMAX = 4;
  localparam int TMO  = 64;

  logic       PCLK = 1'b0, CLEAR_B = 1'b0;
  logic [1:0] REQ = 2'b00, LAST = 2'b00;
  logic [7:0] TXD0 = 8'h00, TXD1 = 8'h00, RxDATA = 8'h00;
  logic       TX_FULL = 1'b0, RECV = 1'b0;
  logic [1:0] GNT, ACK, RVALID;
  logic       TX_WR, BUSY, ERR;
  logic [7:0] TxDATA, RDATA;

  ssp_frame_sched #(.BURST_MAX(BMAX), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .REQ(REQ), .TXD0(TXD0), .TXD1(TXD1),
    .LAST(LAST), .GNT(GNT), .ACK(ACK), .TX_WR(TX_WR), .TxDATA(TxDATA),
    .TX_FULL(TX_FULL), .RxDATA(RxDATA), .RECV(RECV), .RDATA(RDATA),
    .RVALID(RVALID), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0, n_fail = 0, wr_cnt = 0, err_cnt = 0;
  logic [8:0] exp_tx[$], exp_rx[$];   // {owner, data}
  logic [8:0] rq0[$], rq1[$];         // {last, data}
  logic [8:0] e_tx, e_rx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Requester model: presents queue heads, pops on a sampled ACK.
  initial begin : drv
    logic [1:0] acc;
    forever begin
      @(negedge PCLK);
      acc = ACK;
      @(posedge PCLK);
      #1;
      if (acc[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (acc[1] && rq1.size() > 0) void'(rq1.pop_front());
      #1;
      REQ[0]  = rq0.size() > 0;
      REQ[1]  = rq1.size() > 0;
      TXD0    = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
      TXD1    = (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
      LAST[0] = (rq0.size() > 0) && rq0[0][8];
      LAST[1] = (rq1.size() > 0) && rq1[0][8];
    end
  end

  // Monitor / scoreboard
  always @(negedge PCLK) begin
    if (CLEAR_B) begin
      if (TX_FULL) chk("ack_while_full", 32'({TX_WR, ACK}), 32'(0));
      if (TX_WR) begin
        wr_cnt++;
        if (exp_tx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got data %0h, want no write", TxDATA);
        end else begin
          e_tx = exp_tx.pop_front();
          chk("tx_data", 32'(TxDATA), 32'(e_tx[7:0]));
          chk("tx_gnt", 32'(GNT), 32'(1) << e_tx[8]);
          chk("tx_ack", 32'(ACK), 32'(1) << e_tx[8]);
        end
      end
      if (RVALID != 2'b00) begin
        if (exp_rx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rx_unexpected: got rvalid %0h data %0h, want none", RVALID, RDATA);
        end else begin
          e_rx = exp_rx.pop_front();
          chk("rx_owner", 32'(RVALID), 32'(1) << e_rx[8]);
          chk("rx_data", 32'(RDATA), 32'(e_rx[7:0]));
        end
      end
      if (ERR) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    if (r == REQ_A) rq0.push_back({l, d});
    else            rq1.push_back({l, d});
    exp_tx.push_back({r[0], d});
  endtask

  task automatic recv(input int r, input logic [7:0] d, input logic expect_rv);
    RECV   = 1'b1;
    RxDATA = d;
    if (expect_rv) exp_rx.push_back({r[0], d});
    tick();
    RECV   = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_cnt < n && k < 200) begin tick(); k++; end
    chk("wait_wr", 32'(wr_cnt >= n), 32'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY && k < 200) begin tick(); k++; end
    chk("wait_idle", 32'(BUSY), 32'(0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"},    32'(GNT),    32'(0));
    chk({tag, "_ack"},    32'(ACK),    32'(0));
    chk({tag, "_txwr"},   32'(TX_WR),  32'(0));
    chk({tag, "_rvalid"}, 32'(RVALID), 32'(0));
    chk({tag, "_rdata"},  32'(RDATA),  32'(0));
    chk({tag, "_busy"},   32'(BUSY),   32'(0));
    chk({tag, "_err"},    32'(ERR),    32'(0));
  endtask

  initial begin
    int k;
    repeat (2) @(posedge PCLK);
    #1;
    chk_reset("rst");
    CLEAR_B = 1'b1;
    tick();

    // Single requester, three bytes, LAST on the third
    push(REQ_A, 8'hA1, 1'b0); push(REQ_A, 8'hA2, 1'b0); push(REQ_A, 8'hA3, 1'b1);
    wait_wr(3);
    recv(REQ_A, 8'h11, 1'b1); recv(REQ_A, 8'h22, 1'b1); recv(REQ_A, 8'h33, 1'b1);
    tick(); wait_idle();

    // prio is now 1: both request, requester 1 wins first
    push(REQ_B, 8'hB1, 1'b1); push(REQ_A, 8'hC1, 1'b1);
    wait_wr(4); recv(REQ_B, 8'h44, 1'b1);
    wait_wr(5); recv(REQ_A, 8'h55, 1'b1);
    tick(); wait_idle();

    // Write and RECV in the same GRANT cycle leave outstanding unchanged
    push(REQ_A, 8'hD1, 1'b0); push(REQ_A, 8'hD2, 1'b0); push(REQ_A, 8'hD3, 1'b1);
    wait_wr(6);                 // now in the cycle carrying D2
    recv(REQ_A, 8'h66, 1'b1);
    wait_wr(8);
    recv(REQ_A, 8'h77, 1'b1);
    chk("simul_busy", 32'(BUSY), 32'(1));
    recv(REQ_A, 8'h88, 1'b1);
    chk("simul_done", 32'(BUSY), 32'(0));

    // Burst cap with back-pressure: 6 bytes, capped at 4, then re-grant
    for (int i = 0; i < 6; i++) push(REQ_B, 8'(8'hE0 + i), i == 5);
    wait_wr(10);
    TX_FULL = 1'b1;
    repeat (2) tick();
    TX_FULL = 1'b0;
    wait_wr(12);
    repeat (3) tick();
    chk("cap_writes", 32'(wr_cnt), 32'(12));
    chk("cap_gnt", 32'(GNT), 32'(2'b10));
    chk("cap_busy", 32'(BUSY), 32'(1));
    for (int i = 0; i < 4; i++) recv(REQ_B, 8'(8'h91 + i), 1'b1);
    wait_wr(14);
    recv(REQ_B, 8'h95, 1'b1); recv(REQ_B, 8'h96, 1'b1);
    tick(); wait_idle();

    // Timeout: two writes, only one RECV
    push(REQ_A, 8'hF1, 1'b0); push(REQ_A, 8'hF2, 1'b1);
    wait_wr(16);
    recv(REQ_A, 8'hAA, 1'b1);
    k = 0;
    while (!ERR && k < 200) begin tick(); k++; end
    chk("to_latency", 32'(k), 32'(TMO));
    chk("to_gnt", 32'(GNT), 32'(0));
    chk("to_busy", 32'(BUSY), 32'(0));
    tick();
    chk("to_err_pulse", 32'(ERR), 32'(0));
    chk("to_errcnt", 32'(err_cnt), 32'(1));

    // Stray RECV in IDLE
    recv(REQ_A, 8'hBB, 1'b0);
    chk("stray_err", 32'(ERR), 32'(1));
    chk("stray_rvalid", 32'(RVALID), 32'(0));
    tick();
    chk("stray_err_clr", 32'(ERR), 32'(0));
    chk("stray_errcnt", 32'(err_cnt), 32'(2));

    // Reset mid-DRAIN: outputs clear without a clock edge
    push(REQ_B, 8'hC7, 1'b0); push(REQ_B, 8'hC8, 1'b1);
    wait_wr(18);
    chk("pre_rst_busy", 32'(BUSY), 32'(1));
    #2 CLEAR_B = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    tick();

    // Contention from reset: requester 0 first, then 1
    push(REQ_A, 8'h31, 1'b0); push(REQ_A, 8'h32, 1'b1);
    push(REQ_B, 8'h41, 1'b0); push(REQ_B, 8'h42, 1'b1);
    wait_wr(20);
    recv(REQ_A, 8'h01, 1'b1); recv(REQ_A, 8'h02, 1'b1);
    wait_wr(22);
    recv(REQ_B, 8'h03, 1'b1); recv(REQ_B, 8'h04, 1'b1);
    tick(); wait_idle();

    repeat (2) tick();
    chk("tx_left", 32'(exp_tx.size()), 32'(0));
    chk("rx_left", 32'(exp_rx.size()), 32'(0));
    chk("err_total", 32'(err_cnt), 32'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
